udp_rx_probe_tap: RTL

- Passive tap on the 8-bit GMII receive stream of the UDP example. Sits directly upstream of the on-chip debug capture core.
- Parses frame structure: preamble, SFD, body and error.
- Drives an 11-bus, time-aligned probe set sized to the capture core's inputs: 8, 1, 16, 25, 2, 8, 25, 10, 1, 1 and 16 bits.
- Never back-pressures or alters the data path.

---
 rtl/udp_rx_probe_tap.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/udp_rx_probe_tap.sv
// Passive GMII receive tap: two-stage pipeline feeding an aligned probe bus to a debug capture core.
// Stage 1 registers the raw inputs; stage 2 (the probe registers) holds the frame-parser state.
module udp_rx_probe_tap #(
  parameter int unsigned TS_W    = 25,
  parameter int unsigned FCNT_W  = 10,
  parameter int unsigned MIN_PRE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxd,
  input  logic              rx_dv,
  input  logic              rx_er,
  output logic [7:0]        probe_data,
  output logic              probe_valid,
  output logic [15:0]       probe_byte_cnt,
  output logic [TS_W-1:0]   probe_ts,
  output logic [1:0]        probe_state,
  output logic [7:0]        probe_pre_cnt,
  output logic [TS_W-1:0]   probe_sof_ts,
  output logic [FCNT_W-1:0] probe_frame_cnt,
  output logic              probe_sof,
  output logic              probe_eof,
  output logic [15:0]       probe_last_len
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StBody = 2'd2,
    StErr  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        s1_d;
  logic              s1_dv, s1_er;
  logic [TS_W-1:0]   ts_q;
  // Body bytes received so far; probe_byte_cnt shows the index of the current byte instead.
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       idx_d;
  logic [7:0]        pre_d;
  logic [TS_W-1:0]   sof_ts_d;
  logic [FCNT_W-1:0] fcnt_d;
  logic [15:0]       last_d;
  logic              sof_d, eof_d;

  assign probe_state = state_q;

  always_comb begin
    state_d  = state_q;
    pre_d    = probe_pre_cnt;
    cnt_d    = cnt_q;
    idx_d    = probe_byte_cnt;
    sof_ts_d = probe_sof_ts;
    fcnt_d   = probe_frame_cnt;
    last_d   = probe_last_len;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s1_dv) begin
          if (s1_d == 8'h55) begin
            state_d = StPre;
            pre_d   = 8'd1;
          end else begin
            state_d = StErr;
          end
        end
      end
      StPre: begin
        if (!s1_dv) begin
          state_d = StIdle;
          pre_d   = 8'd0;
        end else if (s1_er) begin
          state_d = StErr;
        end else if (s1_d == 8'h55) begin
          if (probe_pre_cnt != 8'hff) pre_d = probe_pre_cnt + 8'd1;
        end else if (s1_d == 8'hd5 && 32'(probe_pre_cnt) >= MIN_PRE) begin
          state_d  = StBody;
          sof_d    = 1'b1;
          sof_ts_d = ts_q;
          cnt_d    = 16'd0;
          idx_d    = 16'd0;
        end else begin
          state_d = StErr;
        end
      end
      StBody: begin
        // dv fall wins over a simultaneous er, so such a frame still counts as good.
        if (!s1_dv) begin
          state_d = StIdle;
          pre_d   = 8'd0;
          eof_d   = 1'b1;
          fcnt_d  = probe_frame_cnt + FCNT_W'(1);
          last_d  = cnt_q;
        end else if (s1_er) begin
          state_d = StErr;
        end else begin
          idx_d = cnt_q;
          if (cnt_q != 16'hffff) cnt_d = cnt_q + 16'd1;
        end
      end
      StErr: begin
        if (!s1_dv) begin
          state_d = StIdle;
          pre_d   = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_d            <= 8'd0;
      s1_dv           <= 1'b0;
      s1_er           <= 1'b0;
      ts_q            <= '0;
      cnt_q           <= 16'd0;
      state_q         <= StIdle;
      probe_data      <= 8'd0;
      probe_valid     <= 1'b0;
      probe_byte_cnt  <= 16'd0;
      probe_ts        <= '0;
      probe_pre_cnt   <= 8'd0;
      probe_sof_ts    <= '0;
      probe_frame_cnt <= '0;
      probe_sof       <= 1'b0;
      probe_eof       <= 1'b0;
      probe_last_len  <= 16'd0;
    end else begin
      s1_d            <= rxd;
      s1_dv           <= rx_dv;
      s1_er           <= rx_er;
      ts_q            <= ts_q + TS_W'(1);
      cnt_q           <= cnt_d;
      state_q         <= state_d;
      probe_data      <= s1_d;
      probe_valid     <= s1_dv;
      probe_byte_cnt  <= idx_d;
      probe_ts        <= ts_q;
      probe_pre_cnt   <= pre_d;
      probe_sof_ts    <= sof_ts_d;
      probe_frame_cnt <= fcnt_d;
      probe_sof       <= sof_d;
      probe_eof       <= eof_d;
      probe_last_len  <= last_d;
    end
  end

endmodule
